// File: rtl/spec_add_seq_pkg.sv
// ============================================================================
// Module      : spec_add_pkg
// Description : Shared types and constants for the speculative adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spec_add_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              fixed;
    } res_t;

endpackage

`default_nettype wire

// File: rtl/spec_add_seq_if.sv
// ============================================================================
// Module      : spec_add_seq_if
// Description : Operand-in / result-out valid-ready bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spec_add_seq_if
    import spec_add_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_cout;
    logic              out_fixed;

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_fixed
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_fixed
    );

endinterface

`default_nettype wire

// File: rtl/spec_add_seq_hc_dp16.sv
// ============================================================================
// Module      : spec_hc_dp16
// Description : Combinational 16-bit speculative adder; carries look back only
//               WIN bits, err flags any bit where the dropped term mattered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spec_hc_dp16
    import spec_add_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] appsum,
    output logic              appcout,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int WIN = 8;

    logic [DATA_W-1:0]   w_g;
    logic [DATA_W-1:0]   w_p;
    logic [DATA_W:0]     w_c;
    logic [DATA_W:0]     w_ac;
    logic [DATA_W-WIN-1:0] w_perr;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < DATA_W; i++) begin : g_exact
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    // Carries within the first WIN bits see the full history, so they are exact.
    assign w_ac[WIN:0] = w_c[WIN:0];

    for (genvar i = WIN + 1; i <= DATA_W; i++) begin : g_win
        logic [WIN:0] w_acc;
        assign w_acc[0] = 1'b0;
        for (genvar k = 0; k < WIN; k++) begin : g_step
            assign w_acc[k+1] = w_g[i-WIN+k] | (w_p[i-WIN+k] & w_acc[k]);
        end
        assign w_ac[i] = w_acc[WIN];
        // A fully propagating window hides the carry entering it.
        assign w_perr[i-WIN-1] = (&w_p[i-1:i-WIN]) & w_c[i-WIN];
    end

    assign appsum  = w_p ^ w_ac[DATA_W-1:0];
    assign appcout = w_ac[DATA_W];
    assign sum     = w_p ^ w_c[DATA_W-1:0];
    assign cout    = w_c[DATA_W];
    assign err     = |w_perr;

endmodule

`default_nettype wire

// File: rtl/spec_add_seq.sv
// ============================================================================
// Module      : spec_add_seq
// Description : Variable-latency sequencer around spec_hc_dp16. Optional
//               result statistics enabled by macro SPEC_ADD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spec_add_seq
    import spec_add_pkg::*;
#(
    parameter int FORCE_FIX = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    spec_add_seq_if.slave    bus,
    output logic             busy
`ifdef SPEC_ADD_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_fixes
`endif
);

    localparam bit C_FORCE = (FORCE_FIX != 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_cin;
    res_t              r_res;
    res_t              w_res_nxt;
    logic              r_out_valid;
    logic              w_in_ready;
    logic              w_load_ops;
    logic              w_load_res;

    logic [DATA_W-1:0] w_appsum;
    logic              w_appcout;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_err;

    spec_hc_dp16 u_dp (
        .a       (r_a),
        .b       (r_b),
        .cin     (r_cin),
        .appsum  (w_appsum),
        .appcout (w_appcout),
        .sum     (w_sum),
        .cout    (w_cout),
        .err     (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load_ops  = 1'b0;
        w_load_res  = 1'b0;
        w_res_nxt   = '{sum: w_appsum, cout: w_appcout, fixed: 1'b0};
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load_ops  = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (!w_err && !C_FORCE) begin
                    w_load_res  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_load_res  = 1'b1;
                w_res_nxt   = '{sum: w_sum, cout: w_cout, fixed: 1'b1};
                w_state_nxt = DONE;
            end
            DONE: begin
                // Accepting the result frees the operand registers this same edge.
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_load_ops  = 1'b1;
                        w_state_nxt = EVAL;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            if (w_load_ops) begin
                r_a   <= bus.in_a;
                r_b   <= bus.in_b;
                r_cin <= bus.in_cin;
            end
            if (w_load_res) begin
                r_res <= w_res_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_res.sum;
    assign bus.out_cout  = r_res.cout;
    assign bus.out_fixed = r_res.fixed;
    assign busy          = (r_state != IDLE);

`ifdef SPEC_ADD_STATS_EN
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_accept;
    logic [CNT_W-1:0] r_ops;
    logic [CNT_W-1:0] r_fixes;

    assign w_accept = (r_state == DONE) && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops   <= '0;
            r_fixes <= '0;
        end else if (w_accept) begin
            if (r_ops != '1) begin
                r_ops <= r_ops + C_ONE;
            end
            if (r_res.fixed && (r_fixes != '1)) begin
                r_fixes <= r_fixes + C_ONE;
            end
        end
    end

    assign stat_ops   = r_ops;
    assign stat_fixes = r_fixes;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spec_add_seq.sv
// ============================================================================
// Module      : tb_spec_add_seq
// Description : Directed and random-stream checks for spec_add_seq; a second
//               instance runs with FORCE_FIX=1 and 2-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spec_add_seq;

    localparam int N_OPS = 1000;

    logic clk;
    logic rst_n;
    logic busy;
    logic f_busy;
`ifdef SPEC_ADD_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_fixes;
    logic [1:0]  f_stat_ops;
    logic [1:0]  f_stat_fixes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spec_add_seq_if m_if ();
    spec_add_seq_if f_if ();

    assign f_if.in_valid  = m_if.in_valid;
    assign f_if.in_a      = m_if.in_a;
    assign f_if.in_b      = m_if.in_b;
    assign f_if.in_cin    = m_if.in_cin;
    assign f_if.out_ready = m_if.out_ready;

    spec_add_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (m_if.slave),
        .busy       (busy)
`ifdef SPEC_ADD_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_fixes (stat_fixes)
`endif
    );

    spec_add_seq #(.FORCE_FIX(1), .CNT_W(2)) u_fix (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (f_if.slave),
        .busy       (f_busy)
`ifdef SPEC_ADD_STATS_EN
        ,
        .stat_ops   (f_stat_ops),
        .stat_fixes (f_stat_fixes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Error reference: carry into bit i rebuilt from the 8 bits below it alone.
    function automatic logic ref_err(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] s;
        logic [16:0] cv;
        logic [8:0]  w;
        logic        e;
        s  = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        cv = s ^ {1'b0, a} ^ {1'b0, b};
        e  = 1'b0;
        for (int i = 9; i <= 16; i++) begin
            w = {1'b0, a[i-1 -: 8]} + {1'b0, b[i-1 -: 8]};
            if (w[8] != cv[i]) e = 1'b1;
        end
        return e;
    endfunction

    task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic ef, input int elat, input string tag);
        int   n;
        logic v;
        m_if.in_a     = a;
        m_if.in_b     = b;
        m_if.in_cin   = ci;
        m_if.in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            m_if.in_valid = 1'b0;
            n++;
            v = sel ? f_if.out_valid : m_if.out_valid;
        end while (!v && n < 10);
        check({tag, "_lat"}, n, elat);
        if (sel) begin
            check({tag, "_res"}, {14'b0, f_if.out_fixed, f_if.out_cout, f_if.out_sum},
                  {14'b0, ef, ec, es});
        end else begin
            check({tag, "_res"}, {14'b0, m_if.out_fixed, m_if.out_cout, m_if.out_sum},
                  {14'b0, ef, ec, es});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [32:0] q[$];
        logic [32:0] e;
        logic [16:0] exp_s;
        logic        ef;
        logic        fired;
        int          nprod;
        int          ncons;
        int          cyc;

        rst_n          = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.in_a      = '0;
        m_if.in_b      = '0;
        m_if.in_cin    = 1'b0;
        m_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", m_if.in_ready, 1);
        check("rst_out_valid", m_if.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", {14'b0, m_if.out_fixed, m_if.out_cout, m_if.out_sum}, 0);
        rst_n = 1'b1;

        // Reset asserted while in EVAL drops the op
        @(posedge clk);
        #1;
        m_if.in_a     = 16'h7FFF;
        m_if.in_b     = 16'h0001;
        m_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", m_if.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_valid", m_if.out_valid, 0);

        // Directed speculative and correction paths, including window boundaries
        run_op(0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b0, 2, "spec");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3, "fix_7fff");
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 3, "fix_cin");
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 2, "win_edge");
        run_op(0, 16'h01FF, 16'h0001, 1'b0, 16'h0200, 1'b0, 1'b1, 3, "win_over");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 3, "wrap");
        run_op(0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0, 2, "cout_spec");

        // Backpressure in DONE with a pending operand pair
        m_if.out_ready = 1'b0;
        m_if.in_a      = 16'h1234;
        m_if.in_b      = 16'h0101;
        m_if.in_cin    = 1'b0;
        m_if.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
        cyc = 0;
        while (!m_if.out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        m_if.in_a     = 16'h0003;
        m_if.in_b     = 16'h0004;
        m_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {m_if.out_valid, m_if.in_ready, m_if.out_fixed, m_if.out_sum},
                  {1'b1, 1'b0, 1'b0, 16'h1335});
        end
        m_if.out_ready = 1'b1;
        #1;
        check("bp_release_ready", m_if.in_ready, 1);
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
        check("bp_latched", {m_if.out_valid, busy}, 2'b01);
        @(posedge clk);
        #1;
        check("bp_new_result", {m_if.out_valid, m_if.out_sum}, {1'b1, 16'h0007});
        @(posedge clk);
        #1;

        // Random back-to-back stream with random consumer stalls
        nprod = 0;
        ncons = 0;
        cyc   = 0;
        while (ncons < N_OPS && cyc < 20000) begin
            if (!m_if.in_valid && nprod < N_OPS) begin
                m_if.in_a     = 16'($urandom);
                m_if.in_b     = 16'($urandom);
                m_if.in_cin   = 1'($urandom);
                m_if.in_valid = 1'b1;
            end
            m_if.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_if.out_valid && m_if.out_ready) begin
                if (q.size() == 0) begin
                    check("stream_underflow", 1, 0);
                end else begin
                    e     = q.pop_front();
                    exp_s = {1'b0, e[32:17]} + {1'b0, e[16:1]} + {16'b0, e[0]};
                    ef    = ref_err(e[32:17], e[16:1], e[0]);
                    check("stream", {14'b0, m_if.out_fixed, m_if.out_cout, m_if.out_sum},
                          {14'b0, ef, exp_s});
                end
                ncons++;
            end
            fired = m_if.in_valid && m_if.in_ready;
            if (fired) begin
                q.push_back({m_if.in_a, m_if.in_b, m_if.in_cin});
                nprod++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fired) m_if.in_valid = 1'b0;
        end
        check("stream_count", ncons, N_OPS);
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;

        // FORCE_FIX instance: speculative-clean vector still takes the fix path
        do_reset();
        run_op(1, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b1, 3, "force_fix");

`ifdef SPEC_ADD_STATS_EN
        do_reset();
        check("stat_rst", {stat_ops, stat_fixes}, 0);
        run_op(0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b0, 2, "st1");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3, "st2");
        run_op(0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 2, "st3");
        check("stat_ops3", stat_ops, 3);
        check("stat_fixes1", stat_fixes, 1);
        run_op(0, 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 2, "st4");
        repeat (4) @(posedge clk);
        #1;
        check("stat_ops4", stat_ops, 4);
        check("stat_sat_ops", f_stat_ops, 3);
        check("stat_sat_fixes", f_stat_fixes, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spec_add_seq.md
Name: spec_add_seq

Overview:
- Variable-latency sequencer around the 16-bit speculative Han-Carlson adder datapath.
- Accepts operand pairs over a valid/ready handshake and registers them.
- Returns the speculative sum when the datapath error flag is clear. When the flag is set, spends one extra cycle and returns the corrected sum instead.
- Sits between an operand producer and a result consumer. Lets the fast path run at speculative latency while exact results are still guaranteed.

Parameters:
- FORCE_FIX, 0: 1 forces every operation through the FIX state regardless of err (debug/characterisation).
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  16  operand A
- in_b  in  16  operand B
- in_cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  16  result sum
- out_cout  out  1  result carry out
- out_fixed  out  1  result came from the correction path
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, operand regs 0, out_sum=0, out_cout=0, out_fixed=0, out_valid=0. Combinational outputs at reset: in_ready=1, busy=0.
- Datapath: combinational, fed from registered operands. Produces appsum/appcout (speculative), sum/cout (corrected) and err.
- States:
  - IDLE: in_ready=1. in_valid → latch a/b/cin, go to EVAL.
  - EVAL: in_ready=0.
    - err=0 and FORCE_FIX=0: load out_sum=appsum, out_cout=appcout, out_fixed=0, go to DONE.
    - otherwise: go to FIX.
  - FIX: in_ready=0. Load out_sum=sum, out_cout=cout, out_fixed=1, go to DONE.
  - DONE: out_valid=1, in_ready=out_ready.
    - out_ready & in_valid: latch new operands, go to EVAL (back-to-back, no bubble on input side).
    - out_ready & !in_valid: go to IDLE.
    - !out_ready: hold. Outputs stable, operands ignored.
- Latency from the accept edge: 2 cycles to out_valid on the speculative path, 3 cycles on the correction path.
- Throughput: one op per 2 cycles (no error) or 3 cycles (error), assuming out_ready=1.
- out_valid is a registered output: 1 only in DONE. out_sum, out_cout and out_fixed change only on the EVAL→DONE or FIX→DONE transition.
- Input operands are never sampled outside IDLE or DONE & out_ready.
- Reset asserted mid-operation (any state) returns immediately to reset values. The in-flight op is dropped and no output is produced.
- Illegal state encoding → IDLE.
- Arithmetic: 16-bit unsigned plus cin. The corrected {cout,sum} always equals a+b+cin. The speculative result is used only when err=0.

Optional Feature:
- Macro SPEC_ADD_STATS_EN.
- When defined, adds outputs stat_ops[CNT_W-1:0] and stat_fixes[CNT_W-1:0], both reset to 0.
  - stat_ops increments on every DONE→(IDLE|EVAL) handoff, i.e. each result accepted.
  - stat_fixes increments on each result accepted with out_fixed=1.
  - Both counters saturate at all-ones; no wrap.
- Without the macro, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package spec_add_pkg holds:
  - state enum (IDLE, EVAL, FIX, DONE; 2-bit)
  - DATA_W=16 constant
  - result struct {sum, cout, fixed}
- One natural sub-module: spec_hc_dp16, the combinational speculative datapath.
  - Inputs: a, b, cin.
  - Outputs: appsum, appcout, sum, cout, err.
- The FSM, handshake and counters live in spec_add_seq.

Test Plan:
1. Reset → in_ready=1, out_valid=0, out_sum=0, busy=0. Assert rst_n low during EVAL → next cycle IDLE, no out_valid.
2. Speculative path: a=0x1234, b=0x0101, cin=0 accepted, out_ready=1 → out_valid 2 cycles later, out_sum=0x1335, out_cout=0, out_fixed=0.
3. Correction path: a=0x7FFF, b=0x0001, cin=0 → out_valid 3 cycles later, out_sum=0x8000, out_cout=0, out_fixed=1. Also a=0xFFFF, b=0x0000, cin=1 → out_sum=0x0000, out_cout=1, out_fixed=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 → outputs stable, in_ready=0, no new op latched. Release → result accepted and the new op latched the same cycle.
5. Back-to-back stream: 1000 random ops with random out_ready → every {cout,sum}=a+b+cin. Order preserved. out_fixed matches the reference err model.
6. FORCE_FIX=1 with vector from scenario 2 → 3-cycle latency, out_fixed=1. With SPEC_ADD_STATS_EN, 3 accepted ops (1 fixed) → stat_ops=3, stat_fixes=1. Counters saturate at 0xFFFF.
